div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl_pkg.sv | 18 +
 rtl/div_fastpath.sv | 19 +
 rtl/div_ctrl.sv | 97 +++++++++
 tb/tb_div_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared func/state encodings and special-case constants
package div_ctrl_pkg;
  typedef enum logic [1:0] {
    FN_DIV  = 2'b00,
    FN_DIVU = 2'b01,
    FN_REM  = 2'b10,
    FN_REMU = 2'b11
  } func_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_e;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
endpackage

// File: rtl/div_fastpath.sv
// div_fastpath: detects divide-by-zero and signed overflow and selects their result
module div_fastpath
  import div_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  func,
  output logic        hit,
  output logic [31:0] result
);
  logic zero, ovf, rem;
  always_comb begin
    zero   = b == '0;
    rem    = func == FN_REM || func == FN_REMU;
    ovf    = (func == FN_DIV || func == FN_REM) && a == INT_MIN && b == DIV0_QUOT;
    hit    = zero || ovf;
    result = zero ? (rem ? a : DIV0_QUOT) : (rem ? '0 : INT_MIN);
  end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: pipeline-side controller sequencing divide/remainder ops through an external divider
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [1:0]  func_i,
  input  logic [4:0]  rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_result_o,
  output logic [4:0]  resp_rd_o,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        div_start_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic [1:0]  div_func_o,
  input  logic [31:0] div_result_i,
  input  logic        div_done_i
);
  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]  func_q, func_d;
  logic [4:0]  rd_q, rd_d;
  logic        fp_hit;
  logic [31:0] fp_res;
  div_fastpath u_fastpath (
    .a      (op_a_i),
    .b      (op_b_i),
    .func   (func_i),
    .hit    (fp_hit),
    .result (fp_res)
  );
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    func_d       = func_q;
    rd_d         = rd_q;
    res_d        = res_q;
    req_ready_o  = rst_ni && state_q == S_IDLE && !flush_i;
    div_start_o  = 1'b0;
    resp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid_i && req_ready_o) begin
        a_d     = op_a_i;
        b_d     = op_b_i;
        func_d  = func_i;
        rd_d    = rd_i;
        res_d   = fp_res;
        state_d = fp_hit ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        div_start_o = !flush_i;
        state_d     = flush_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        res_d   = div_done_i && !flush_i ? div_result_i : res_q;
        state_d = div_done_i ? (flush_i ? S_IDLE : S_RESP) : (flush_i ? S_DRAIN : S_WAIT);
      end
      S_DRAIN: state_d = div_done_i ? S_IDLE : S_DRAIN;
      S_RESP: begin
        resp_valid_o = !flush_i;
        state_d      = flush_i || resp_ready_i ? S_IDLE : S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
    end
  end
  assign busy_o        = state_q != S_IDLE;
  assign div_a_o       = a_q;
  assign div_b_o       = b_q;
  assign div_func_o    = func_q;
  assign resp_result_o = res_q;
  assign resp_rd_o     = rd_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: scoreboard bench for div_ctrl with a behavioural divider and reference model
module tb_div_ctrl;
  import div_ctrl_pkg::*;
  localparam int D = 34;
  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [31:0] op_a_i = '0, op_b_i = '0;
  logic [1:0]  func_i = '0;
  logic [4:0]  rd_i = '0;
  logic        resp_valid_o, resp_ready_i = 1'b1;
  logic [31:0] resp_result_o;
  logic [4:0]  resp_rd_o;
  logic        flush_i = 1'b0, busy_o;
  logic        div_start_o;
  logic [31:0] div_a_o, div_b_o;
  logic [1:0]  div_func_o;
  logic [31:0] div_result_i = '0;
  logic        div_done_i = 1'b0;
  div_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .func_i(func_i), .rd_i(rd_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o), .resp_rd_o(resp_rd_o),
    .flush_i(flush_i), .busy_o(busy_o),
    .div_start_o(div_start_o), .div_a_o(div_a_o), .div_b_o(div_b_o), .div_func_o(div_func_o),
    .div_result_i(div_result_i), .div_done_i(div_done_i)
  );
  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;
  int n_tests = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    logic sgn = f == FN_DIV || f == FN_REM;
    logic rem = f == FN_REM || f == FN_REMU;
    if (b == 0) return rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    return rem ? a % b : a / b;
  endfunction
  function automatic bit ref_fast(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f);
    return b == 0 || ((f == FN_DIV || f == FN_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          exp_cyc;
    int          acc;
    bit          slow;
  } exp_t;
  exp_t sb[$];
  bit          pend = 0, spurious_en = 0;
  int          done_cyc = 0;
  logic [31:0] la, lb;
  logic [1:0]  lf;
  initial forever begin
    @(posedge clk_i);
    #1;
    if (!rst_ni) pend = 0;
    if (pend && cyc == done_cyc) begin
      div_done_i   = 1'b1;
      div_result_i = ref_res(la, lb, lf);
      pend         = 0;
      check("div_a_stable", div_a_o, la);
      check("div_b_stable", div_b_o, lb);
      check("div_func_stable", div_func_o, lf);
    end else begin
      div_done_i   = spurious_en && !pend && $urandom_range(0, 15) == 0;
      div_result_i = $urandom;
    end
    @(negedge clk_i);
    if (!rst_ni) pend = 0;
    else if (div_start_o) begin
      pend     = 1;
      done_cyc = cyc + D;
      la       = div_a_o;
      lb       = div_b_o;
      lf       = div_func_o;
    end
  end
  int ready_mode = 0;
  initial forever begin
    @(posedge clk_i);
    #1;
    resp_ready_i = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  bit in_v = 0;
  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) begin
      sb.delete();
      in_v = 0;
      continue;
    end
    if (div_start_o)
      check("start_timing", sb.size() > 0 && sb[0].slow && cyc == sb[0].acc + 1 && !flush_i, 1);
    if (sb.size() > 0 && cyc > sb[0].acc) check("busy", busy_o, 1);
    if (resp_valid_o) begin
      if (sb.size() == 0) check("resp_unexpected", resp_valid_o, 0);
      else begin
        if (!in_v) check("latency", cyc, sb[0].exp_cyc);
        check("result", resp_result_o, sb[0].res);
        check("rd", resp_rd_o, sb[0].rd);
        in_v = !resp_ready_i;
        if (resp_ready_i) void'(sb.pop_front());
      end
    end else in_v = 0;
    if (flush_i) begin
      check("valid_on_flush", resp_valid_o, 0);
      sb.delete();
      in_v = 0;
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f, input logic [4:0] rd, output int acc);
    exp_t e;
    int n = 0;
    req_valid_i = 1'b1;
    op_a_i = a;
    op_b_i = b;
    func_i = f;
    rd_i = rd;
    acc = 0;
    forever begin
      @(negedge clk_i);
      if (req_ready_o) break;
      if (++n > 200) begin
        check("accept_timeout", req_ready_o, 1);
        step(1);
        req_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
    end
    acc       = cyc;
    e.res     = ref_res(a, b, f);
    e.rd      = rd;
    e.slow    = !ref_fast(a, b, f);
    e.acc     = acc;
    e.exp_cyc = acc + (e.slow ? 2 + D : 1);
    sb.push_back(e);
    step(1);
    req_valid_i = 1'b0;
    op_a_i = $urandom;
    op_b_i = $urandom;
    func_i = 2'($urandom);
    rd_i = 5'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy_o) && n < 300) begin
      step(1);
      n++;
    end
    check("idle_timeout", n < 300, 1);
  endtask
  task automatic check_zero(input string name);
    check({name, "_ready"}, req_ready_o, 0);
    check({name, "_valid"}, resp_valid_o, 0);
    check({name, "_busy"}, busy_o, 0);
    check({name, "_start"}, div_start_o, 0);
    check({name, "_result"}, resp_result_o, 0);
    check({name, "_rd"}, resp_rd_o, 0);
    check({name, "_div_a"}, div_a_o, 0);
    check({name, "_div_b"}, div_b_o, 0);
    check({name, "_div_func"}, div_func_o, 0);
  endtask
  function automatic logic [31:0] pick_a();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 200);
      default: return $urandom;
    endcase
  endfunction
  function automatic logic [31:0] pick_b();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
  initial begin
    int acc;
    #3;
    check_zero("reset");
    step(2);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", req_ready_o, 1);
    check("busy_after_reset", busy_o, 0);
    step(1);
    issue(32'd100, 32'd7, FN_DIV, 5'd3, acc);
    wait_idle();
    issue(32'hFFFF_FF9C, 32'd7, FN_REM, 5'd4, acc);
    wait_idle();
    issue(32'hFFFF_FF9C, 32'd7, FN_DIVU, 5'd5, acc);
    wait_idle();
    issue(32'd5, 32'd0, FN_DIVU, 5'd6, acc);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, FN_REM, 5'd7, acc);
    wait_idle();
    issue(32'h8000_0000, 32'hFFFF_FFFF, FN_DIV, 5'd8, acc);
    wait_idle();
    issue(32'd9, 32'd3, FN_DIV, 5'd9, acc);
    step(9);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    while (cyc < acc + 2 + D) begin
      @(negedge clk_i);
      if (cyc < acc + 1 + D) begin
        check("drain_ready", req_ready_o, 0);
        check("drain_busy", busy_o, 1);
      end
      step(1);
    end
    wait_idle();
    issue(32'd9, 32'd3, FN_DIV, 5'd10, acc);
    wait_idle();
    ready_mode = 2;
    issue(32'd1000, 32'd9, FN_REMU, 5'd11, acc);
    step(1 + D);
    step(5);
    ready_mode = 0;
    wait_idle();
    issue(32'd77, 32'd5, FN_DIV, 5'd12, acc);
    step(D);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_done_busy", busy_o, 0);
    check("flush_done_valid", resp_valid_o, 0);
    step(3);
    issue(32'h1234_5678, 32'd13, FN_DIVU, 5'd13, acc);
    step(14);
    #2;
    rst_ni = 1'b0;
    #1;
    check_zero("rst_wait");
    step(2);
    rst_ni = 1'b1;
    step(D + 4);
    spurious_en = 1;
    ready_mode = 1;
    for (int i = 0; i < 150; i++) begin
      step($urandom_range(0, 2));
      issue(pick_a(), pick_b(), 2'($urandom), 5'($urandom), acc);
      if ($urandom_range(0, 3) == 0) begin
        step($urandom_range(0, 40));
        flush_i = 1'b1;
        step(1);
        flush_i = 1'b0;
      end
    end
    ready_mode = 0;
    wait_idle();
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
